// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the program counter, drives the external PC+4 adder
// and holds the IF/ID pipeline register along with a saturating fetch counter.
module if_stage #(
   parameter int unsigned         PC_WIDTH    = 8,
   parameter int unsigned         INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = 8'h00
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_target,
   input  logic                   jump,
   input  logic [PC_WIDTH-1:0]    jump_target,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [PC_WIDTH-1:0]    adder_din1,
   output logic [PC_WIDTH-1:0]    adder_din2,
   output logic                   adder_cin,
   input  logic [PC_WIDTH-1:0]    adder_dout,
   output logic [INSTR_WIDTH-1:0] ifid_instr,
   output logic [PC_WIDTH-1:0]    ifid_pc4,
   output logic                   ifid_valid,
   output logic [15:0]            fetch_count
);

   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_next;
   logic                squash;
   logic                load;
   logic                unused_target_bits;

   // Targets are forced word-aligned, so their low bits never matter.
   assign unused_target_bits = ^{branch_target[1:0], jump_target[1:0]};

   assign squash = flush | branch_taken | jump;
   assign load   = ~squash & ~stall;

   assign imem_addr  = pc;
   assign adder_din1 = pc;
   assign adder_din2 = PC_WIDTH'(4);
   assign adder_cin  = 1'b0;

   // Branch beats jump: it belongs to the older instruction in EX.
   always_comb begin
      pc_next = adder_dout;
      if (branch_taken) begin
         pc_next = {branch_target[PC_WIDTH-1:2], 2'b00};
      end else if (jump) begin
         pc_next = {jump_target[PC_WIDTH-1:2], 2'b00};
      end else if (stall) begin
         pc_next = pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || squash) begin
         ifid_instr <= '0;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
      end else if (load) begin
         ifid_instr <= imem_rdata;
         ifid_pc4   <= adder_dout;
         ifid_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count <= '0;
      end else if (load && (fetch_count != 16'hFFFF)) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a driver pushes model predictions, a negedge monitor
// pops and compares them against the DUT; directed boundary cases then random traffic.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, branch_taken, jump;
   logic [7:0]  branch_target, jump_target;
   logic [7:0]  imem_addr, adder_din1, adder_din2, adder_dout, ifid_pc4;
   logic        adder_cin, ifid_valid;
   logic [31:0] imem_rdata, ifid_instr;
   logic [15:0] fetch_count;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int          stamp;
      logic [7:0]  pc;
      logic [31:0] instr;
      logic [7:0]  pc4;
      logic        valid;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];

   // Reference state, advanced once per issued cycle.
   logic [7:0]  m_pc    = 8'h00;
   logic [31:0] m_instr = '0;
   logic [7:0]  m_pc4   = '0;
   logic        m_valid = 1'b0;
   int          m_cnt   = 0;

   // Distinct bits in every byte so corrupted instruction lanes show up.
   function automatic logic [31:0] mem_word(input logic [7:0] a);
      return {~a, 8'h5A, a ^ 8'h3C, a};
   endfunction

   always #5 clk = ~clk;

   assign imem_rdata = mem_word(imem_addr);
   assign adder_dout = adder_din1 + adder_din2 + {7'b0, adder_cin};

   if_stage #(.PC_WIDTH(8), .INSTR_WIDTH(32), .RESET_PC(8'h00)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .adder_din1    (adder_din1),
      .adder_din2    (adder_din2),
      .adder_cin     (adder_cin),
      .adder_dout    (adder_dout),
      .ifid_instr    (ifid_instr),
      .ifid_pc4      (ifid_pc4),
      .ifid_valid    (ifid_valid),
      .fetch_count   (fetch_count)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compare every prediction whose cycle has arrived.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].stamp <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.stamp < cyc) begin
            chk("stale_entry", 32'(cyc), 32'(e.stamp));
         end else begin
            chk("pc",          {24'h0, imem_addr},  {24'h0, e.pc});
            chk("adder_din1",  {24'h0, adder_din1}, {24'h0, e.pc});
            chk("adder_din2",  {24'h0, adder_din2}, 32'h4);
            chk("adder_cin",   {31'h0, adder_cin},  32'h0);
            chk("ifid_instr",  ifid_instr,          e.instr);
            chk("ifid_pc4",    {24'h0, ifid_pc4},   {24'h0, e.pc4});
            chk("ifid_valid",  {31'h0, ifid_valid}, {31'h0, e.valid});
            chk("fetch_count", {16'h0, fetch_count}, {16'h0, e.cnt});
         end
      end
   end

   // Apply one cycle of inputs, predict the state after the coming edge, wait for it.
   task automatic step(input bit r, input bit s, input bit f, input bit b,
                       input logic [7:0] bt, input bit j, input logic [7:0] jt);
      exp_t e;
      rst = r; stall = s; flush = f; branch_taken = b; branch_target = bt;
      jump = j; jump_target = jt;
      if (r) begin
         m_pc = 8'h00; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_cnt = 0;
      end else begin
         logic [7:0] seq;
         seq = 8'((int'(m_pc) + 4) % 256);
         if (f || b || j) begin
            m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
         end else if (!s) begin
            m_instr = mem_word(m_pc); m_pc4 = seq; m_valid = 1'b1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
         end
         if (b)      m_pc = bt & 8'hFC;
         else if (j) m_pc = jt & 8'hFC;
         else if (!s) m_pc = seq;
      end
      e.stamp = cyc + 1; e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
      e.valid = m_valid; e.cnt = 16'(m_cnt);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic free(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 0, 8'h00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(1, 0, 0, 0, 8'h00, 0, 8'h00);
      step(1, 0, 0, 0, 8'h00, 0, 8'h00);
      free(4);
      // Wrap-around at the top of the address space.
      step(0, 0, 0, 0, 8'h00, 1, 8'hF8);
      free(3);
      // Stall at pc 10 with the 0C instruction in IF/ID.
      step(0, 0, 0, 0, 8'h00, 1, 8'h0C);
      free(1);
      step(0, 1, 0, 0, 8'h00, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00, 0, 8'h00);
      free(2);
      // Branch beats jump and stall; target low bits are dropped.
      step(0, 1, 0, 1, 8'h43, 1, 8'h80);
      free(2);
      // Flush alone at pc 20.
      step(0, 0, 0, 0, 8'h00, 1, 8'h20);
      step(0, 0, 1, 0, 8'h00, 0, 8'h00);
      free(1);
      // Reset during a stall with a valid instruction held.
      free(1);
      step(1, 1, 0, 0, 8'h00, 0, 8'h00);
      free(2);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 8'($urandom),
              $urandom_range(0, 7) == 0, 8'($urandom));
      end
      // Saturation of the fetch counter.
      step(1, 0, 0, 0, 8'h00, 0, 8'h00);
      free(65537);
      chk("fetch_count_sat", {16'h0, fetch_count}, 32'h0000FFFF);
      free(2);
      chk("fetch_count_hold", {16'h0, fetch_count}, 32'h0000FFFF);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
